// File: rtl/ssram_pkg.sv
// Shared types for the pixel-buffer SSRAM arbiter: requester IDs, bus states
// and the round-robin pick between the PPU and CPU ports.
package ssram_pkg;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT_VGA = 2'd0;
  localparam port_id_t PORT_PPU = 2'd1;
  localparam port_id_t PORT_CPU = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    TURN  = 2'd2,
    WRITE = 2'd3
  } bus_state_e;

  // Round-robin winner between PPU and CPU; ptr_cpu = 1 favours the CPU on a tie.
  function automatic port_id_t rr_pick(input logic elig_ppu, input logic elig_cpu,
                                       input logic ptr_cpu);
    port_id_t pick;
    if (elig_ppu && elig_cpu) begin
      pick = ptr_cpu ? PORT_CPU : PORT_PPU;
    end else if (elig_cpu) begin
      pick = PORT_CPU;
    end else begin
      pick = PORT_PPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ssram_read_tag_pipe.sv
// READ_LAT-deep shift register of read tags (requester ID + valid). A tag
// pushed with a read grant emerges exactly when that read's data is on DQ.
module ssram_read_tag_pipe
  import ssram_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  port_id_t push_id,
  output logic     pop_valid,
  output port_id_t pop_id,
  output logic     inflight,
  output logic     stay
);

  logic [READ_LAT-1:0] vld_r;
  port_id_t            id_r [READ_LAT];

  // Shift tags one stage per clock; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        id_r[i] <= PORT_VGA;
      end
    end else begin
      vld_r[0] <= push;
      id_r[0]  <= push_id;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        id_r[i]  <= id_r[i-1];
      end
    end
  end

  // A tag in any stage but the last will still be in flight next cycle.
  always_comb begin
    stay = 1'b0;
    for (int i = 0; i < READ_LAT - 1; i++) begin
      stay = stay | vld_r[i];
    end
  end

  assign inflight  = |vld_r;
  assign pop_valid = vld_r[READ_LAT-1];
  assign pop_id    = id_r[READ_LAT-1];

endmodule

// File: rtl/ssram_arbiter.sv
// Three-port arbiter/sequencer for the pixel-buffer SSRAM. Port 0 (VGA) has
// fixed priority, ports 1/2 (PPU/CPU) share round-robin, a starvation guard
// bounds VGA monopoly, and a bus FSM inserts the read-to-write turnaround.
module ssram_arbiter
  import ssram_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [ADDR_W-1:0]     addr_0,
  input  logic [DATA_W-1:0]     wdata_0,
  input  logic [DATA_W/8-1:0]   be_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [ADDR_W-1:0]     addr_1,
  input  logic [DATA_W-1:0]     wdata_1,
  input  logic [DATA_W/8-1:0]   be_1,
  input  logic                  req_2,
  input  logic                  we_2,
  input  logic [ADDR_W-1:0]     addr_2,
  input  logic [DATA_W-1:0]     wdata_2,
  input  logic [DATA_W/8-1:0]   be_2,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic                  gnt_2,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic                  rvalid_2,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ssram_adsc_n,
  output logic                  ssram_we_n,
  output logic                  ssram_oe_n,
  output logic [DATA_W/8-1:0]   ssram_be_n,
  output logic [ADDR_W-1:0]     ssram_addr,
  output logic [DATA_W-1:0]     ssram_dq_out,
  output logic                  ssram_dq_oe,
  input  logic [DATA_W-1:0]     ssram_dq_in
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  bus_state_e          state_r, state_nxt_s;
  logic                rr_r;
  logic [CNT_W-1:0]    starve_cnt_r;
  logic                write_ok_s, elig_1_s, elig_2_s, rr_valid_s, starve_hit_s;
  port_id_t            rr_id_s, gnt_id_s, pop_id_s;
  logic                gnt_any_s, push_s, pop_valid_s, inflight_s, stay_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W/8-1:0] sel_be_s;
  logic                unused_we_0_s;

  // The VGA port only ever reads, so its write strobe is ignored.
  assign unused_we_0_s = we_0;

  assign starve_hit_s = (starve_cnt_r == STARVE_LIM);
  assign push_s       = gnt_any_s & ~sel_we_s;

  // Pick this cycle's grant: writes wait for the read pipe to drain, the
  // starvation guard hands the slot to the round-robin winner.
  always_comb begin
    write_ok_s = ((state_r == IDLE) || (state_r == WRITE)) && !inflight_s;
    elig_1_s   = req_1 && (!we_1 || write_ok_s);
    elig_2_s   = req_2 && (!we_2 || write_ok_s);
    rr_valid_s = elig_1_s || elig_2_s;
    rr_id_s    = rr_pick(elig_1_s, elig_2_s, rr_r);
    gnt_any_s  = 1'b0;
    gnt_id_s   = PORT_VGA;
    if (RESET) begin
      gnt_any_s = 1'b0;
    end else if (rr_valid_s && (starve_hit_s || !req_0)) begin
      gnt_any_s = 1'b1;
      gnt_id_s  = rr_id_s;
    end else if (req_0) begin
      gnt_any_s = 1'b1;
      gnt_id_s  = PORT_VGA;
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  // Route the granted requester's command fields toward the pin registers.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = addr_0;
    sel_wdata_s = wdata_0;
    sel_be_s    = be_0;
    case (gnt_id_s)
      PORT_PPU: begin
        sel_we_s    = we_1;
        sel_addr_s  = addr_1;
        sel_wdata_s = wdata_1;
        sel_be_s    = be_1;
      end
      PORT_CPU: begin
        sel_we_s    = we_2;
        sel_addr_s  = addr_2;
        sel_wdata_s = wdata_2;
        sel_be_s    = be_2;
      end
      default: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = addr_0;
        sel_wdata_s = wdata_0;
        sel_be_s    = be_0;
      end
    endcase
  end

  assign gnt_0 = gnt_any_s & (gnt_id_s == PORT_VGA);
  assign gnt_1 = gnt_any_s & (gnt_id_s == PORT_PPU);
  assign gnt_2 = gnt_any_s & (gnt_id_s == PORT_CPU);

  // Bus direction FSM: READ holds until the last tag reaches its final stage,
  // then TURN gives the SSRAM one cycle to release DQ.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, WRITE, TURN: begin
        if (gnt_any_s) begin
          state_nxt_s = sel_we_s ? WRITE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (gnt_any_s || stay_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = TURN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, round-robin pointer and starvation counter.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r      <= IDLE;
      rr_r         <= 1'b0;
      starve_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (gnt_any_s && (gnt_id_s != PORT_VGA)) begin
        rr_r         <= ~rr_r;
        starve_cnt_r <= '0;
      end else if (!(req_1 || req_2)) begin
        starve_cnt_r <= '0;
      end else if (gnt_any_s && !starve_hit_s) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // Registered SSRAM pins: the granted command appears the cycle after gnt.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ssram_adsc_n <= 1'b1;
      ssram_we_n   <= 1'b1;
      ssram_oe_n   <= 1'b1;
      ssram_be_n   <= '1;
      ssram_addr   <= '0;
      ssram_dq_out <= '0;
      ssram_dq_oe  <= 1'b0;
    end else begin
      ssram_oe_n <= ~(push_s | stay_s);
      if (gnt_any_s) begin
        ssram_adsc_n <= 1'b0;
        ssram_we_n   <= ~sel_we_s;
        ssram_be_n   <= ~sel_be_s;
        ssram_addr   <= sel_addr_s;
        ssram_dq_out <= sel_wdata_s;
        ssram_dq_oe  <= sel_we_s;
      end else begin
        ssram_adsc_n <= 1'b1;
        ssram_we_n   <= 1'b1;
        ssram_be_n   <= '1;
        ssram_dq_oe  <= 1'b0;
      end
    end
  end

  // Capture read data when its tag emerges and flag the owning port.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rdata    <= '0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rvalid_2 <= 1'b0;
    end else begin
      rvalid_0 <= pop_valid_s & (pop_id_s == PORT_VGA);
      rvalid_1 <= pop_valid_s & (pop_id_s == PORT_PPU);
      rvalid_2 <= pop_valid_s & (pop_id_s == PORT_CPU);
      if (pop_valid_s) begin
        rdata <= ssram_dq_in;
      end else begin
        rdata <= rdata;
      end
    end
  end

  ssram_read_tag_pipe #(.READ_LAT(READ_LAT)) u_tag_pipe (
    .clk      (CLOCK),
    .rst      (RESET),
    .push     (push_s),
    .push_id  (gnt_id_s),
    .pop_valid(pop_valid_s),
    .pop_id   (pop_id_s),
    .inflight (inflight_s),
    .stay     (stay_s)
  );

endmodule
